// File: rtl/mrr_decoded_packetizer_pkg.sv
// Shared constants and types for the decoded-packet framer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mrr_decoded_packetizer_pkg;

    // Upper half of the first header word; the lower half carries the payload length.
    localparam logic [15:0] PKT_MAGIC = 16'h4D52;

    // One committed packet: capture time of its first word plus its payload length in words.
    typedef struct packed {
        logic [63:0] ts;
        logic [15:0] len;
    } meta_t;

    typedef enum logic [2:0] {
        EG_IDLE,
        EG_HDR,
        EG_TS_HI,
        EG_TS_LO,
        EG_PAY
    } eg_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mrr_pkt_meta_fifo.sv
// Synchronous FIFO of committed-packet metadata with registered full/empty flags.
// Latency: a push is visible at the head (empty deasserted) the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates on the flags.
//
// Ports: clk/rst (async active-high), push/push_dat write side, pop/pop_dat read side
//        (pop_dat is the current head, valid whenever empty is low), full/empty status.
module mrr_pkt_meta_fifo #(
    parameter int W          = 80,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_push = push & ~full_q;
        do_pop  = pop & ~empty_q;
        wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        full_d  = (cnt_d == CNT_FULL);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/mrr_decoded_packetizer.sv
// Store-and-forward framer: buffers tlast-delimited 32b packets and emits each behind a magic/len, ts_hi, ts_lo header.
// Latency: header valid two cycles after the ingress tlast beat at the earliest; then 1 word/cycle with o_tready high.
// Backpressure: i_tready drops only when the metadata FIFO is full; overflowing or oversize packets are dropped whole.
//
// Ports: clk/rst (async active-high), cur_time (64b timestamp source), clear_stats (sync clear of drop_count),
//        i_t* ingress AXI-stream, o_t* framed egress AXI-stream (registered), drop_count (saturating 16b).
module mrr_decoded_packetizer
    import mrr_decoded_packetizer_pkg::*;
#(
    parameter int BUF_DEPTH_LOG2  = 9,
    parameter int META_DEPTH_LOG2 = 3,
    parameter int MAX_PKT_WORDS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cur_time,
    input  logic        clear_stats,
    input  logic [31:0] i_tdata,
    input  logic        i_tvalid,
    input  logic        i_tlast,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    input  logic        o_tready,
    output logic [15:0] drop_count
);

    localparam int AW = BUF_DEPTH_LOG2;
    localparam logic [AW:0] BUF_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0] LEN_ONE  = 16'd1;
    localparam logic [15:0] LEN_MAX  = 16'(MAX_PKT_WORDS);

    logic [31:0] mem [2**AW];

    // Ingress state
    logic [AW:0]   wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d;
    logic [15:0]   pkt_len_q, pkt_len_d, drop_count_q, drop_count_d;
    logic [63:0]   ts_hold_q, ts_hold_d;
    logic          in_pkt_q, in_pkt_d, drop_flag_q, drop_flag_d;
    // Egress state
    eg_state_t     state_q, state_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   o_tdata_q, o_tdata_d;
    logic          o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
    logic [15:0]   cur_len_q, cur_len_d, rem_q, rem_d;
    logic [63:0]   cur_ts_q, cur_ts_d;

    logic          beat, buf_full, first_beat, drop_now, drop_inc, mem_we;
    logic [AW:0]   start_sel;
    logic [15:0]   len_base, len_next;
    logic [63:0]   ts_sel;
    logic          meta_push, meta_pop, meta_full, meta_empty, load_hdr;
    meta_t         meta_in, meta_out;
    logic [31:0]   rd_word;

    assign i_tready = ~meta_full;

    // Ingress: write words as they arrive; commit via the meta FIFO on tlast, or rewind on drop.
    always_comb begin
        beat       = i_tvalid & i_tready;
        buf_full   = ((wr_ptr_q - rd_ptr_q) == BUF_FULL);
        first_beat = ~in_pkt_q;
        start_sel  = first_beat ? wr_ptr_q : pkt_start_q;
        len_base   = first_beat ? 16'd0 : pkt_len_q;
        len_next   = len_base + LEN_ONE;
        ts_sel     = first_beat ? cur_time : ts_hold_q;
        // A stale drop_flag cannot leak into a new packet: it only counts mid-packet.
        drop_now   = (~first_beat & drop_flag_q) | buf_full | (len_next > LEN_MAX);
        meta_in    = '{ts: ts_sel, len: len_next};

        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        pkt_len_d   = pkt_len_q;
        ts_hold_d   = ts_hold_q;
        in_pkt_d    = in_pkt_q;
        drop_flag_d = drop_flag_q;
        mem_we      = 1'b0;
        meta_push   = 1'b0;
        drop_inc    = 1'b0;

        if (beat) begin
            if (!drop_now) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (i_tlast) begin
                in_pkt_d    = 1'b0;
                drop_flag_d = 1'b0;
                if (drop_now) begin
                    wr_ptr_d = start_sel;
                    drop_inc = 1'b1;
                end else begin
                    meta_push = 1'b1;
                end
            end else begin
                in_pkt_d    = 1'b1;
                drop_flag_d = drop_now;
                pkt_start_d = start_sel;
                ts_hold_d   = ts_sel;
                pkt_len_d   = drop_now ? len_base : len_next;
            end
        end

        if (clear_stats) begin
            drop_count_d = drop_inc ? 16'd1 : 16'd0;
        end else if (drop_inc) begin
            drop_count_d = sat_inc16(drop_count_q);
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Egress: outputs only move when the current beat is taken (or nothing is presented).
    always_comb begin
        state_d    = state_q;
        o_tdata_d  = o_tdata_q;
        o_tvalid_d = o_tvalid_q;
        o_tlast_d  = o_tlast_q;
        cur_len_d  = cur_len_q;
        cur_ts_d   = cur_ts_q;
        rem_d      = rem_q;
        rd_ptr_d   = rd_ptr_q;
        meta_pop   = 1'b0;
        load_hdr   = 1'b0;
        rd_word    = mem[rd_ptr_q[AW-1:0]];

        case (state_q)
            EG_IDLE: load_hdr = ~meta_empty;
            EG_HDR: if (o_tready) begin
                o_tdata_d = cur_ts_q[63:32];
                state_d   = EG_TS_HI;
            end
            EG_TS_HI: if (o_tready) begin
                o_tdata_d = cur_ts_q[31:0];
                state_d   = EG_TS_LO;
            end
            EG_TS_LO: if (o_tready) begin
                o_tdata_d = rd_word;
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                rem_d     = cur_len_q - LEN_ONE;
                o_tlast_d = (cur_len_q == LEN_ONE);
                state_d   = EG_PAY;
            end
            EG_PAY: if (o_tready) begin
                if (rem_q != 16'd0) begin
                    o_tdata_d = rd_word;
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    rem_d     = rem_q - LEN_ONE;
                    o_tlast_d = (rem_q == LEN_ONE);
                end else if (!meta_empty) begin
                    // Chain straight into the next header so back-to-back packets have no bubble.
                    load_hdr = 1'b1;
                end else begin
                    o_tvalid_d = 1'b0;
                    o_tlast_d  = 1'b0;
                    state_d    = EG_IDLE;
                end
            end
            default: state_d = EG_IDLE;
        endcase

        if (load_hdr) begin
            meta_pop   = 1'b1;
            cur_len_d  = meta_out.len;
            cur_ts_d   = meta_out.ts;
            o_tdata_d  = {PKT_MAGIC, meta_out.len};
            o_tvalid_d = 1'b1;
            o_tlast_d  = 1'b0;
            state_d    = EG_HDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            pkt_start_q  <= '0;
            pkt_len_q    <= '0;
            ts_hold_q    <= '0;
            in_pkt_q     <= 1'b0;
            drop_flag_q  <= 1'b0;
            drop_count_q <= '0;
            state_q      <= EG_IDLE;
            rd_ptr_q     <= '0;
            o_tdata_q    <= '0;
            o_tvalid_q   <= 1'b0;
            o_tlast_q    <= 1'b0;
            cur_len_q    <= '0;
            cur_ts_q     <= '0;
            rem_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            pkt_start_q  <= pkt_start_d;
            pkt_len_q    <= pkt_len_d;
            ts_hold_q    <= ts_hold_d;
            in_pkt_q     <= in_pkt_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            o_tdata_q    <= o_tdata_d;
            o_tvalid_q   <= o_tvalid_d;
            o_tlast_q    <= o_tlast_d;
            cur_len_q    <= cur_len_d;
            cur_ts_q     <= cur_ts_d;
            rem_q        <= rem_d;
        end
    end

    // Payload RAM: synchronous write, asynchronous read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= i_tdata;
        end
    end

    mrr_pkt_meta_fifo #(
        .W          ($bits(meta_t)),
        .DEPTH_LOG2 (META_DEPTH_LOG2)
    ) u_meta_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (meta_push),
        .push_dat (meta_in),
        .pop      (meta_pop),
        .pop_dat  (meta_out),
        .full     (meta_full),
        .empty    (meta_empty)
    );

    assign o_tdata    = o_tdata_q;
    assign o_tvalid   = o_tvalid_q;
    assign o_tlast    = o_tlast_q;
    assign drop_count = drop_count_q;

endmodule
